gen_reg32: RTL and testbench
============================

Name: gen_reg32

Overview:
- General-purpose load-enabled register, WIDTH bits (default 32), for the CPU datapath.
- Used for GPRs, PC, IR, MDR, MAR, HI/LO, Y and Z.
- Captures the bus value on a rising clock edge when enabled, holds it otherwise, and clears synchronously.
- Also provides registered zero and sign status flags, used by conditional-branch logic.

Parameters:
- WIDTH, 32, data width in bits; legal range 1 to 64.
- RST_VAL, 0 (WIDTH bits), value Q takes on reset.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- clr  input  1  synchronous active-low reset; 0 at a rising clk edge resets the register.
- enable  input  1  load enable, active-high.
- D  input  WIDTH  data to load (the bus).
- Q  output  WIDTH  stored value.
- q_zero  output  1  high when the stored value is all zeros.
- q_neg  output  1  copy of stored Q[WIDTH-1] (sign).

Behaviour:
- Single clock domain. No asynchronous paths except the combinational outputs listed below.
- Rising edge with clr=0: Q<=RST_VAL. Regardless of enable or D.
  - q_zero <= (RST_VAL==0).
  - q_neg <= RST_VAL[WIDTH-1].
- Rising edge with clr=1 and enable=1: Q<=D, q_zero<=(D==0), q_neg<=D[WIDTH-1]. Load latency is 1 cycle; the new value is visible after the edge.
- Rising edge with clr=1 and enable=0: all state holds.
- Priority: reset over load over hold.
- clr is sampled only at edges. A low pulse between edges has no effect. There is no reset from power-up; contents are X until the first reset or load.
- Flags are registered alongside Q, never recomputed from D combinationally. They are always consistent with Q: q_zero==(Q==0) and q_neg==Q[WIDTH-1] after every edge.
- D is loaded unmodified at full width: no truncation, no sign extension, no bit reordering.
- Users that need narrower fields (e.g. MAR low 9 bits for the address) slice Q externally.
- Back-to-back loads on consecutive edges are allowed; each cycle captures that cycle's D.
- D changing while enable=0 does not disturb Q or the flags.
- Reset asserted in the same cycle as enable: reset wins, and D is discarded.
- Q drives directly from flops; no output glitching from D or enable.

Optional Feature:
- Macro GEN_REG32_PARITY_EN.
- When defined:
  - Extra output q_par (1 bit), registered, equal to the XOR-reduction of Q, updated in the same cycle as Q.
  - On reset, q_par = XOR-reduction of RST_VAL.
  - Extra input chk_en (1 bit) and output par_err (1 bit). par_err is combinational: par_err = chk_en & (q_par != ^Q).
  - par_err is 0 in normal operation and exists for fault-injection checks.
- When undefined: q_par, chk_en and par_err do not exist. Port list is exactly clk, clr, enable, D, Q, q_zero, q_neg, and behaviour is otherwise identical.

Test Plan:
- Reset: clr=0 for one edge with enable=1, D=32'hDEADBEEF -> Q=0, q_zero=1, q_neg=0.
- Load: clr=1, enable=1, D=32'h00000087 at edge -> Q=32'h87 after that edge, q_zero=0, q_neg=0.
- Hold: enable=0, D toggled through 32'hFFFFFFA7 and 0 over 3 edges -> Q stays 32'h87, flags unchanged.
- Sign and zero: load 32'hFFFFFFA7 -> q_neg=1, q_zero=0. Next edge load 0 -> q_zero=1, q_neg=0.
- Reset/enable collision, with RST_VAL=32'h00000005 instance: Q=32'h58, then clr=0 with enable=1, D=32'h34 -> Q=32'h5. Then clr=1, enable=1, D=32'h34 -> Q=32'h34. Also pulse clr low between edges only -> no change.
- Parity (with GEN_REG32_PARITY_EN): load 32'h00000007 -> q_par=1. Load 32'h00000003 -> q_par=0. par_err=0 throughout with chk_en=1.

Source files
------------

// File: rtl/gen_reg32.sv
// gen_reg32: load-enabled WIDTH-bit datapath register with registered zero/sign flags.
// Defining GEN_REG32_PARITY_EN adds a registered parity bit (q_par) and a parity checker (chk_en/par_err).
module gen_reg32 #(
    parameter int unsigned      WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             enable,
    input  logic [WIDTH-1:0] D,
`ifdef GEN_REG32_PARITY_EN
    input  logic             chk_en,
    output logic             q_par,
    output logic             par_err,
`endif
    output logic [WIDTH-1:0] Q,
    output logic             q_zero,
    output logic             q_neg
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic             zero_reg;
    logic             zero_next;
    logic             neg_reg;
    logic             neg_next;

    // Flags are derived from the value about to be stored, so they always match Q after the edge.
    always_comb begin
        q_next = q_reg;
        if (!clr) begin
            q_next = RST_VAL;
        end else if (enable) begin
            q_next = D;
        end
        zero_next = ~|q_next;
        neg_next  = q_next[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        q_reg    <= q_next;
        zero_reg <= zero_next;
        neg_reg  <= neg_next;
    end

    assign Q      = q_reg;
    assign q_zero = zero_reg;
    assign q_neg  = neg_reg;

`ifdef GEN_REG32_PARITY_EN
    logic par_reg;
    logic par_next;

    always_comb begin
        par_next = ^q_next;
    end

    always_ff @(posedge clk) begin
        par_reg <= par_next;
    end

    assign q_par   = par_reg;
    // Recomputes parity from the stored value; only a corrupted flop can make these disagree.
    assign par_err = chk_en & (par_reg != ^q_reg);
`endif

endmodule

// File: tb/tb_gen_reg32.sv
// tb_gen_reg32: directed-vector bench for gen_reg32 (default reset value and RST_VAL=5 instances).
`timescale 1ns/1ps
module tb_gen_reg32;

    logic        clk;
    logic        clr_a, en_a;
    logic [31:0] d_a, q_a;
    logic        zero_a, neg_a;
    logic        clr_b, en_b;
    logic [31:0] d_b, q_b;
    logic        zero_b, neg_b;
`ifdef GEN_REG32_PARITY_EN
    logic        chk_en;
    logic        par_a, perr_a, par_b, perr_b;
`endif

    int n_checks;
    int n_fail;

    gen_reg32 #(.WIDTH(32)) dut_a (
        .clk    (clk),
        .clr    (clr_a),
        .enable (en_a),
        .D      (d_a),
`ifdef GEN_REG32_PARITY_EN
        .chk_en (chk_en),
        .q_par  (par_a),
        .par_err(perr_a),
`endif
        .Q      (q_a),
        .q_zero (zero_a),
        .q_neg  (neg_a)
    );

    gen_reg32 #(.WIDTH(32), .RST_VAL(32'h0000_0005)) dut_b (
        .clk    (clk),
        .clr    (clr_b),
        .enable (en_b),
        .D      (d_b),
`ifdef GEN_REG32_PARITY_EN
        .chk_en (chk_en),
        .q_par  (par_b),
        .par_err(perr_b),
`endif
        .Q      (q_b),
        .q_zero (zero_b),
        .q_neg  (neg_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end else begin
            $display("ok   %s: %0h", tag, observed);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic [31:0] q, input logic z, input logic n);
        check({tag, ".Q"}, 64'(q_a), 64'(q));
        check({tag, ".zero"}, 64'(zero_a), 64'(z));
        check({tag, ".neg"}, 64'(neg_a), 64'(n));
    endtask

    task automatic check_b(input string tag, input logic [31:0] q, input logic z, input logic n);
        check({tag, ".Q"}, 64'(q_b), 64'(q));
        check({tag, ".zero"}, 64'(zero_b), 64'(z));
        check({tag, ".neg"}, 64'(neg_b), 64'(n));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clr_a = 1'b1; en_a = 1'b0; d_a = '0;
        clr_b = 1'b1; en_b = 1'b0; d_b = '0;
`ifdef GEN_REG32_PARITY_EN
        chk_en = 1'b1;
`endif

        // Reset beats enable and discards D.
        clr_a = 1'b0; en_a = 1'b1; d_a = 32'hDEAD_BEEF;
        tick();
        check_a("reset_a", 32'h0, 1'b1, 1'b0);
`ifdef GEN_REG32_PARITY_EN
        check("reset_a.par", 64'(par_a), 64'(0));
`endif

        clr_a = 1'b1; en_a = 1'b1; d_a = 32'h0000_0087;
        tick();
        check_a("load87", 32'h87, 1'b0, 1'b0);

        // Hold with D wandering.
        en_a = 1'b0;
        d_a = 32'hFFFF_FFA7; tick(); check_a("hold1", 32'h87, 1'b0, 1'b0);
        d_a = 32'h0000_0000; tick(); check_a("hold2", 32'h87, 1'b0, 1'b0);
        d_a = 32'hFFFF_FFA7; tick(); check_a("hold3", 32'h87, 1'b0, 1'b0);

        en_a = 1'b1;
        d_a = 32'hFFFF_FFA7; tick(); check_a("load_neg", 32'hFFFF_FFA7, 1'b0, 1'b1);
        d_a = 32'h0000_0000; tick(); check_a("load_zero", 32'h0, 1'b1, 1'b0);
        d_a = 32'h8000_0000; tick(); check_a("load_msb", 32'h8000_0000, 1'b0, 1'b1);
        d_a = 32'h1234_5678; tick(); check_a("b2b1", 32'h1234_5678, 1'b0, 1'b0);
        d_a = 32'hA5A5_5A5A; tick(); check_a("b2b2", 32'hA5A5_5A5A, 1'b0, 1'b1);

        // clr low only between edges is ignored.
        en_a = 1'b0;
        clr_a = 1'b0; #3; clr_a = 1'b1;
        tick();
        check_a("clr_glitch_a", 32'hA5A5_5A5A, 1'b0, 1'b1);

`ifdef GEN_REG32_PARITY_EN
        en_a = 1'b1;
        d_a = 32'h0000_0007; tick();
        check("par7", 64'(par_a), 64'(1));
        check("par7.err", 64'(perr_a), 64'(0));
        d_a = 32'h0000_0003; tick();
        check("par3", 64'(par_a), 64'(0));
        check("par3.err", 64'(perr_a), 64'(0));
        en_a = 1'b0;
`endif

        // Instance with non-zero reset value.
        clr_b = 1'b0; en_b = 1'b0; d_b = 32'h0;
        tick();
        check_b("reset_b", 32'h5, 1'b0, 1'b0);
`ifdef GEN_REG32_PARITY_EN
        check("reset_b.par", 64'(par_b), 64'(0));
        check("reset_b.err", 64'(perr_b), 64'(0));
`endif
        clr_b = 1'b1; en_b = 1'b1; d_b = 32'h0000_0058;
        tick();
        check_b("load58", 32'h58, 1'b0, 1'b0);
        clr_b = 1'b0; en_b = 1'b1; d_b = 32'h0000_0034;
        tick();
        check_b("collide", 32'h5, 1'b0, 1'b0);
        clr_b = 1'b1; en_b = 1'b1; d_b = 32'h0000_0034;
        tick();
        check_b("load34", 32'h34, 1'b0, 1'b0);
        en_b = 1'b0;
        clr_b = 1'b0; #3; clr_b = 1'b1;
        tick();
        check_b("clr_glitch_b", 32'h34, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
